// File: rtl/wb_def.sv
// rtl/wb_def.sv - shared types, widths and address-match helper for the posted-write buffer
package wb_def;

    localparam int WB_ADDR_W = 16;
    localparam int WB_DATA_W = 32;
    localparam int WB_BE_W   = WB_DATA_W / 8;
    localparam int WB_OFFS_W = $clog2(WB_BE_W);

    // One queued posted write
    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_BE_W-1:0]   be;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4
    } wb_state_e;

    // Two addresses overlap when they name the same data word
    function automatic logic word_match(input logic [WB_ADDR_W-1:0] a,
                                        input logic [WB_ADDR_W-1:0] b);
        return a[WB_ADDR_W-1:WB_OFFS_W] == b[WB_ADDR_W-1:WB_OFFS_W];
    endfunction

endpackage

// File: rtl/write_buffer_if.sv
// rtl/write_buffer_if.sv - core memory protocol bundle used on both sides of the write buffer
interface write_buffer_if #(
    parameter int ADDR_WIDTH = wb_def::WB_ADDR_W,
    parameter int DATA_WIDTH = wb_def::WB_DATA_W
);
    logic                    req;
    logic                    gnt;
    logic                    rvalid;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH-1:0]   rdata;

    // Requester side
    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
    // Responder side
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - posted-write storage with pointers, count and an age-ordered entry view
module wb_fifo import wb_def::*; #(
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  wb_entry_t        push_entry_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output wb_entry_t        head_o,
    output wb_entry_t        view_o [DEPTH],
    output logic [DEPTH-1:0] view_valid_o
);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // View slot 0 is the oldest entry; higher slots are progressively newer
    for (genvar i = 0; i < DEPTH; i++) begin : g_view
        assign view_o[i]       = mem_q[rd_ptr_q + PW'(i)];
        assign view_valid_o[i] = (count_q > (PW+1)'(i));
    end

    // Next pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, pop_i};
    end

    // Pointer and count state, cleared by reset so queued writes are discarded
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful under the valid mask
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

endmodule

// File: rtl/write_buffer.sv
// rtl/write_buffer.sv - posted-write buffer between cache and data memory
module write_buffer import wb_def::*; #(
    parameter int DEPTH = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    write_buffer_if.slave  in_data,
    write_buffer_if.master out_data
);
    wb_state_e            state_q, state_d;
    logic [WB_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [WB_BE_W-1:0]   rd_be_q, rd_be_d;
    logic                 rvalid_q, rvalid_d;
    logic [WB_DATA_W-1:0] rdata_q, rdata_d;

    logic                 fifo_full, fifo_empty, fifo_pop, fifo_push;
    wb_entry_t            fifo_head;
    wb_entry_t            fifo_view [DEPTH];
    logic [DEPTH-1:0]     fifo_valid;

    logic                 hit_any;
    logic [WB_BE_W-1:0]   hit_be;
    logic [WB_DATA_W-1:0] hit_data;
    logic                 local_ok, wr_gnt, fwd_gnt, rd_miss;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (fifo_push),
        .push_entry_i ('{addr: in_data.addr, be: in_data.be, data: in_data.wdata}),
        .pop_i        (fifo_pop),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .head_o       (fifo_head),
        .view_o       (fifo_view),
        .view_valid_o (fifo_valid)
    );

    // Find the newest queued entry overlapping the upstream address
    always_comb begin
        hit_any  = 1'b0;
        hit_be   = '0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i] && word_match(fifo_view[i].addr, in_data.addr)) begin
                hit_any  = 1'b1;
                hit_be   = fifo_view[i].be;
                hit_data = fifo_view[i].data;
            end
        end
    end

    // Locally served requests are blocked while a read miss owns the upstream port
    assign local_ok  = (state_q != RD_REQ) && (state_q != RD_WAIT);
    assign wr_gnt    = in_data.req && in_data.we && !fifo_full && local_ok;
    assign fwd_gnt   = in_data.req && !in_data.we && hit_any && (&hit_be) && local_ok;
    assign rd_miss   = in_data.req && !in_data.we && !hit_any;
    assign fifo_push = wr_gnt;

    assign in_data.gnt    = wr_gnt || fwd_gnt || ((state_q == RD_REQ) && out_data.gnt);
    assign in_data.rvalid = rvalid_q || ((state_q == RD_WAIT) && out_data.rvalid);
    assign in_data.rdata  = rvalid_q ? rdata_q :
                            ((state_q == RD_WAIT) && out_data.rvalid) ? out_data.rdata : '0;

    // Downstream sequencing: read misses win over draining, one transaction at a time
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_be_d   = rd_be_q;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_miss) begin
                    state_d   = RD_REQ;
                    rd_addr_d = in_data.addr;
                    rd_be_d   = in_data.be;
                end else if (!fifo_empty) begin
                    state_d = WR_REQ;
                end
            end
            WR_REQ:  if (out_data.gnt) state_d = WR_WAIT;
            WR_WAIT: begin
                if (out_data.rvalid) begin
                    fifo_pop = 1'b1;
                    state_d  = IDLE;
                end
            end
            RD_REQ:  if (out_data.gnt) state_d = RD_WAIT;
            RD_WAIT: if (out_data.rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Upstream response for writes and forwarded reads lands one cycle after grant
    always_comb begin
        rvalid_d = wr_gnt || fwd_gnt;
        rdata_d  = fwd_gnt ? hit_data : '0;
    end

    // Downstream request is decoded from registered state; idle bus is driven to zero
    always_comb begin
        out_data.req   = 1'b0;
        out_data.we    = 1'b0;
        out_data.addr  = '0;
        out_data.be    = '0;
        out_data.wdata = '0;
        case (state_q)
            WR_REQ: begin
                out_data.req   = 1'b1;
                out_data.we    = 1'b1;
                out_data.addr  = fifo_head.addr;
                out_data.be    = fifo_head.be;
                out_data.wdata = fifo_head.data;
            end
            RD_REQ: begin
                out_data.req  = 1'b1;
                out_data.addr = rd_addr_q;
                out_data.be   = rd_be_q;
            end
            default: ;
        endcase
    end

    // Control and response registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            rd_be_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            rd_be_q   <= rd_be_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_write_buffer.sv
// tb/tb_write_buffer.sv - directed and randomized self-checking bench for write_buffer
module tb_write_buffer;
    import wb_def::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    write_buffer_if in_bus ();
    write_buffer_if out_bus ();

    write_buffer #(.DEPTH(4)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .in_data  (in_bus),
        .out_data (out_bus)
    );

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    txn_t        log_q [$];
    txn_t        exp_wr_q [$];
    logic [31:0] mem_img [int];
    logic [31:0] ref_mem [int];
    int gnt_delay = 0;
    int rsp_lat = 1;
    bit stall = 1'b0;
    int wr_done = 0;
    int wr_pushed = 0;
    int first_wr_rv_cyc = -1;
    int last_gnt_cyc = 0;
    int wr_done_at_gnt = 0;
    int n_reads_ds = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_default(input int w);
        return 32'hC0DE0000 ^ (w * 32'h11);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mem_get(input int k);
        return mem_img.exists(k) ? mem_img[k] : mem_default(k);
    endfunction

    function automatic logic [31:0] ref_get(input int k);
        return ref_mem.exists(k) ? ref_mem[k] : mem_default(k);
    endfunction

    // Memory responder: grant after gnt_delay request cycles, rvalid rsp_lat cycles later
    initial begin
        bit          pending, hs, resp_wr;
        int          lat, req_cnt, k;
        logic [31:0] resp;
        txn_t        e;
        pending = 0; req_cnt = 0; lat = 0; resp = '0; resp_wr = 0;
        out_bus.gnt = 1'b0; out_bus.rvalid = 1'b0; out_bus.rdata = '0;
        forever begin
            @(negedge clk);
            hs = out_bus.req && out_bus.gnt;
            if (!rst_n) begin
                pending = 0; req_cnt = 0; hs = 0;
            end else if (!out_bus.req) begin
                check("ds_idle_zero", {out_bus.we, out_bus.be, out_bus.addr, out_bus.wdata}, 64'd0);
            end
            if (hs) begin
                k = int'(out_bus.addr >> 2);
                log_q.push_back('{out_bus.addr, out_bus.we, out_bus.be, out_bus.wdata});
                if (out_bus.we) begin
                    if (exp_wr_q.size() == 0) begin
                        check("ds_unexpected_write", {48'd0, out_bus.addr}, 64'hFFFF_FFFF);
                    end else begin
                        e = exp_wr_q.pop_front();
                        check("ds_write_order", {out_bus.addr, out_bus.be, out_bus.wdata},
                              {e.addr, e.be, e.wdata});
                    end
                    mem_img[k] = merge(mem_get(k), out_bus.wdata, out_bus.be);
                    resp = '0;
                end else begin
                    n_reads_ds++;
                    resp = mem_get(k);
                end
                resp_wr = out_bus.we; pending = 1; lat = rsp_lat; req_cnt = 0;
            end
            @(posedge clk); #1;
            out_bus.gnt = 1'b0; out_bus.rvalid = 1'b0; out_bus.rdata = '0;
            if (!rst_n) begin
                pending = 0; req_cnt = 0;
            end else if (pending) begin
                lat--;
                if (lat <= 0) begin
                    out_bus.rvalid = 1'b1; out_bus.rdata = resp; pending = 0;
                    if (resp_wr) begin
                        wr_done++;
                        if (first_wr_rv_cyc < 0) first_wr_rv_cyc = cyc;
                    end
                end
            end else if (out_bus.req && !stall) begin
                if (req_cnt >= gnt_delay) out_bus.gnt = 1'b1;
                else req_cnt++;
            end
        end
    end

    task automatic up_write(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d,
                            output int gwait);
        int k;
        @(negedge clk);
        in_bus.req = 1'b1; in_bus.we = 1'b1; in_bus.addr = a; in_bus.be = be; in_bus.wdata = d;
        gwait = 0;
        #1;
        while (!in_bus.gnt && gwait < 300) begin @(negedge clk); #1; gwait++; end
        if (!in_bus.gnt) begin
            check("wr_gnt_timeout", 64'd0, 64'd1);
            in_bus.req = 1'b0;
            return;
        end
        last_gnt_cyc = cyc;
        k = int'(a >> 2);
        ref_mem[k] = merge(ref_get(k), d, be);
        exp_wr_q.push_back('{a, 1'b1, be, d});
        wr_pushed++;
        @(negedge clk);
        in_bus.req = 1'b0; in_bus.we = 1'b0;
        #1;
        check("wr_rvalid_next", in_bus.rvalid, 1);
        check("wr_rdata_zero", in_bus.rdata, 0);
    endtask

    task automatic up_read(input logic [15:0] a, output logic [31:0] d, output int gwait,
                           output int rlat);
        @(negedge clk);
        in_bus.req = 1'b1; in_bus.we = 1'b0; in_bus.addr = a; in_bus.be = 4'hF; in_bus.wdata = '0;
        gwait = 0; rlat = -1; d = '0;
        #1;
        while (!in_bus.gnt && gwait < 300) begin @(negedge clk); #1; gwait++; end
        if (!in_bus.gnt) begin
            check("rd_gnt_timeout", 64'd0, 64'd1);
            in_bus.req = 1'b0;
            return;
        end
        last_gnt_cyc = cyc;
        wr_done_at_gnt = wr_done;
        @(negedge clk);
        in_bus.req = 1'b0;
        #1;
        rlat = 1;
        while (!in_bus.rvalid && rlat < 300) begin @(negedge clk); #1; rlat++; end
        if (!in_bus.rvalid) check("rd_rvalid_timeout", 64'd0, 64'd1);
        d = in_bus.rdata;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((wr_done != wr_pushed) && n < 2000) begin @(negedge clk); n++; end
        check("drain_done", wr_done, wr_pushed);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        logic [15:0] a;
        logic [3:0]  be;
        logic [3:0]  be_tab [4];
        int gw, rl, nrd, nreq;
        be_tab[0] = 4'hF; be_tab[1] = 4'h3; be_tab[2] = 4'hC; be_tab[3] = 4'hF;
        in_bus.req = 1'b0; in_bus.we = 1'b0; in_bus.addr = '0; in_bus.be = '0; in_bus.wdata = '0;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_gnt", in_bus.gnt, 0);
        check("rst_in_rvalid", in_bus.rvalid, 0);
        check("rst_in_rdata", in_bus.rdata, 0);
        check("rst_out_req", out_bus.req, 0);
        check("rst_out_addr", out_bus.addr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write, slow memory grant
        gnt_delay = 3;
        up_write(16'h0010, 4'hF, 32'hDEADBEEF, gw);
        check("t1_gnt_same_cycle", gw, 0);
        wait_drain();
        check("t1_mem_written", mem_get(4), 32'hDEADBEEF);

        // Fill with memory stalled, fifth write held until first pop
        gnt_delay = 0; stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_write(16'h0200 + 16'(i * 4), 4'hF, 32'h1000_0000 + i, gw);
            check("t2_fill_gnt", gw, 0);
        end
        first_wr_rv_cyc = -1;
        fork
            up_write(16'h0210, 4'hF, 32'h5555_AAAA, gw);
            begin
                repeat (5) begin
                    @(negedge clk); #2;
                    check("t2_full_no_gnt", in_bus.gnt, 0);
                end
                stall = 1'b0;
            end
        join
        check("t2_gnt_after_pop", last_gnt_cyc, first_wr_rv_cyc + 1);
        wait_drain();

        // Forward hit from a full-word queued write
        gnt_delay = 4;
        up_write(16'h0020, 4'hF, 32'h12345678, gw);
        nrd = n_reads_ds;
        up_read(16'h0020, d, gw, rl);
        check("t3_fwd_data", d, 32'h12345678);
        check("t3_fwd_gnt", gw, 0);
        check("t3_fwd_lat", rl, 1);
        check("t3_no_ds_read", n_reads_ds, nrd);
        wait_drain();

        // Partial overlap blocks the read until the write completes
        gnt_delay = 2;
        up_write(16'h0030, 4'h3, 32'hAABBCCDD, gw);
        up_read(16'h0030, d, gw, rl);
        check("t4_gnt_withheld", gw > 0, 1);
        check("t4_write_done_first", wr_done_at_gnt, wr_pushed);
        check("t4_ds_read", {log_q[$].we, log_q[$].addr}, {1'b0, 16'h0030});
        check("t4_rdata", d, ref_get(16'h0030 >> 2));
        wait_drain();

        // Read miss jumps ahead of the remaining drain
        gnt_delay = 0; stall = 1'b1;
        up_write(16'h0050, 4'hF, 32'h0000_5050, gw);
        up_write(16'h0054, 4'hF, 32'h0000_5454, gw);
        fork
            up_read(16'h0040, d, gw, rl);
            begin repeat (3) @(negedge clk); stall = 1'b0; end
        join
        check("t5_rdata", d, ref_get(16'h0040 >> 2));
        wait_drain();
        check("t5_order_w0", {log_q[$-2].we, log_q[$-2].addr}, {1'b1, 16'h0050});
        check("t5_order_rd", {log_q[$-1].we, log_q[$-1].addr}, {1'b0, 16'h0040});
        check("t5_order_w1", {log_q[$].we, log_q[$].addr}, {1'b1, 16'h0054});

        // Reset in the middle of a drain discards the queue
        rsp_lat = 20;
        up_write(16'h0060, 4'hF, 32'h6060_6060, gw);
        up_write(16'h0064, 4'hF, 32'h6464_6464, gw);
        up_write(16'h0068, 4'hF, 32'h6868_6868, gw);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_out_req_drop", out_bus.req, 0);
        check("t6_in_rvalid", in_bus.rvalid, 0);
        check("t6_in_rdata", in_bus.rdata, 0);
        exp_wr_q.delete();
        wr_pushed = wr_done;
        ref_mem = mem_img;
        rsp_lat = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nreq = 0;
        repeat (20) begin @(negedge clk); if (out_bus.req) nreq++; end
        check("t6_no_req_after_reset", nreq, 0);

        // Randomized mix checked against the architectural memory image
        for (int i = 0; i < 60; i++) begin
            gnt_delay = $urandom_range(0, 3);
            rsp_lat   = $urandom_range(1, 3);
            a = 16'h0100 + 16'($urandom_range(0, 3) * 4);
            if ($urandom_range(0, 1) == 1) begin
                be = be_tab[$urandom_range(0, 3)];
                up_write(a, be, $urandom, gw);
            end else begin
                up_read(a, d, gw, rl);
                check("rnd_rdata", d, ref_get(int'(a >> 2)));
            end
        end
        wait_drain();
        foreach (ref_mem[k]) check("final_mem", mem_get(k), ref_mem[k]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
